// File: rtl/car_pkg.sv
// Shared car definitions: direction codes, footprint sizes, screen size and scan states.
// Used by the collision scanner and by the sprite drawer so both agree on the footprint.
package car_pkg;

  typedef enum logic [2:0] {
    DIR_E, DIR_NE, DIR_N, DIR_NW, DIR_W, DIR_SW, DIR_S, DIR_SE
  } dir_t;

  localparam int LONG_SIDE  = 14;
  localparam int SHORT_SIDE = 8;
  localparam int DIAG_SIDE  = 15;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EVAL, DONE} state_t;

  typedef struct packed {
    logic [3:0] w;
    logic [3:0] h;
  } dims_t;

  // Odd codes are diagonals; even codes with bit 1 set point north/south.
  function automatic dims_t dims_for_dir(input logic [2:0] dir);
    dims_t d;
    if (dir[0]) begin
      d.w = 4'(DIAG_SIDE);
      d.h = 4'(DIAG_SIDE);
    end else if (dir[1]) begin
      d.w = 4'(SHORT_SIDE);
      d.h = 4'(LONG_SIDE);
    end else begin
      d.w = 4'(LONG_SIDE);
      d.h = 4'(SHORT_SIDE);
    end
    return d;
  endfunction

endpackage

// File: rtl/footprint_scanner.sv
// Raster col/row walker over a W x H footprint; 'last' marks the bottom-right pixel.
module footprint_scanner
  import car_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  dims_t      dims,
  input  logic       advance,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       last
);

  logic [3:0] width;
  logic [3:0] height;

  always_ff @(posedge clk) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      width  <= '0;
      height <= '0;
    end else if (load) begin
      col    <= '0;
      row    <= '0;
      width  <= dims.w;
      height <= dims.h;
    end else if (advance) begin
      if (col == width - 4'd1) begin
        col <= '0;
        row <= row + 4'd1;
      end else begin
        col <= col + 4'd1;
      end
    end
  end

  assign last = (col == width - 4'd1) && (row == height - 4'd1);

endmodule

// File: rtl/car_collision_scan.sv
// Reads back the car footprint from the framebuffer and reports wall or off-screen hits.
// Define COLLISION_FULL_SCAN_EN to scan the whole footprint and expose oHitCount.
module car_collision_scan
  import car_pkg::*;
#(
  parameter int         X_SCREEN_PIXELS = SCREEN_W,
  parameter int         Y_SCREEN_PIXELS = SCREEN_H,
  parameter logic [8:0] WALL_COLOUR     = 9'h000
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [2:0] iDir,
  output logic       oBusy,
  output logic       oRdReq,
  output logic [7:0] oRdX,
  output logic [6:0] oRdY,
  input  logic [8:0] iRdData,
  input  logic       iRdValid,
  output logic       oDone,
  output logic       oHit,
  output logic [7:0] oHitX,
  output logic [6:0] oHitY
`ifdef COLLISION_FULL_SCAN_EN
  ,
  output logic [7:0] oHitCount
`endif
);

`ifdef COLLISION_FULL_SCAN_EN
  localparam logic EARLY_STOP = 1'b0;
`else
  localparam logic EARLY_STOP = 1'b1;
`endif

  state_t     state;
  logic [7:0] x_base;
  logic [6:0] y_base;
  logic       pix_hit;
  logic [3:0] col;
  logic [3:0] row;
  logic       last;
  logic       load;
  logic       advance;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       off_screen;

  // One extra address bit so a footprint hanging past the edge never wraps back on-screen.
  assign pix_x      = {1'b0, x_base} + {5'd0, col};
  assign pix_y      = {1'b0, y_base} + {4'd0, row};
  assign off_screen = (pix_x >= 9'(X_SCREEN_PIXELS)) || (pix_y >= 8'(Y_SCREEN_PIXELS));

  assign load    = (state == IDLE) && iStart;
  assign advance = (state == EVAL) && !(pix_hit && EARLY_STOP) && !last;

  footprint_scanner u_scanner (
    .clk    (iClock),
    .reset  (iReset),
    .load   (load),
    .dims   (dims_for_dir(iDir)),
    .advance(advance),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= IDLE;
      x_base  <= '0;
      y_base  <= '0;
      pix_hit <= 1'b0;
      oBusy   <= 1'b0;
      oRdReq  <= 1'b0;
      oRdX    <= '0;
      oRdY    <= '0;
      oDone   <= 1'b0;
      oHit    <= 1'b0;
      oHitX   <= '0;
      oHitY   <= '0;
`ifdef COLLISION_FULL_SCAN_EN
      oHitCount <= '0;
`endif
    end else begin
      oRdReq <= 1'b0;
      oDone  <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            x_base <= iX;
            y_base <= iY;
            oHit   <= 1'b0;
            oHitX  <= '0;
            oHitY  <= '0;
`ifdef COLLISION_FULL_SCAN_EN
            oHitCount <= '0;
`endif
            oBusy  <= 1'b1;
            state  <= REQ;
          end
        end
        // Off-screen pixels are obstacles by definition and are never read.
        REQ: begin
          if (off_screen) begin
            pix_hit <= 1'b1;
            state   <= EVAL;
          end else begin
            oRdReq <= 1'b1;
            oRdX   <= pix_x[7:0];
            oRdY   <= pix_y[6:0];
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (iRdValid) begin
            pix_hit <= (iRdData == WALL_COLOUR);
            state   <= EVAL;
          end
        end
        EVAL: begin
          if (pix_hit && !oHit) begin
            oHit  <= 1'b1;
            oHitX <= pix_x[7:0];
            oHitY <= pix_y[6:0];
          end
`ifdef COLLISION_FULL_SCAN_EN
          if (pix_hit && (oHitCount != 8'hFF)) oHitCount <= oHitCount + 8'd1;
`endif
          if ((pix_hit && EARLY_STOP) || last) begin
            oDone <= 1'b1;
            state <= DONE;
          end else begin
            state <= REQ;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/car_collision_scan.md
Name: car_collision_scan

Overview:
- Read-side counterpart to the car sprite drawer. It walks the car's footprint rectangle at a requested position and direction, and reads each pixel back from the framebuffer read port.
- It reports whether any pixel matches the wall colour or lies off-screen.
- The game controller runs it before committing a move. The drawer then paints the car only if no hit is reported.

Parameters:
- X_SCREEN_PIXELS, 160, screen width; x >= this is off-screen
- Y_SCREEN_PIXELS, 120, screen height; y >= this is off-screen
- WALL_COLOUR, 9'h000, 9-bit {R,G,B} colour treated as obstacle

Ports:
- iClock  in  1  system clock
- iReset  in  1  one clock; reset is synchronous and active-high
- iStart  in  1  start-scan pulse; sampled only when idle
- iX  in  8  footprint upper-left x
- iY  in  7  footprint upper-left y
- iDir  in  3  car direction code 0..7
- oBusy  out  1  high from the cycle after accepted iStart until oDone
- oRdReq  out  1  one-cycle read request
- oRdX  out  8  read x, valid with oRdReq
- oRdY  out  7  read y, valid with oRdReq
- iRdData  in  9  pixel colour returned
- iRdValid  in  1  iRdData valid; exactly one per request, any latency >= 1
- oDone  out  1  one-cycle completion pulse
- oHit  out  1  result, held until next accepted iStart
- oHitX  out  8  coordinate of first hit pixel, held
- oHitY  out  7  coordinate of first hit pixel, held

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE and counters clear. Reset mid-scan abandons the scan; a late iRdValid in IDLE is ignored.
- Footprint dimensions (W x H):
  - dir 0/4: 14x8
  - dir 2/6: 8x14
  - dir odd: 15x15
- Scan order is raster: col 0..W-1 inner, row 0..H-1 outer. Pixel address = (iX+col, iY+row), computed at 9/8 bits so the sum cannot wrap.
- iStart in IDLE latches iX, iY and iDir, clears oHit/oHitX/oHitY and enters REQ. iStart while busy is ignored. Inputs may change after the accepting cycle.
- FSM transitions:
  - IDLE -> REQ on iStart.
  - REQ, address off-screen: no read is issued. The pixel counts as a hit and goes directly to the EVAL logic.
  - REQ, address on-screen: oRdReq=1 with oRdX/oRdY for one cycle -> WAIT.
  - WAIT: hold until iRdValid. Hit if iRdData == WALL_COLOUR. -> EVAL.
  - EVAL: on a hit, if oHit was 0, set oHit=1 and capture the address into oHitX/oHitY. Early-terminate -> DONE. Otherwise, on the last pixel -> DONE, else advance the counter -> REQ.
  - DONE: oDone=1 for one cycle -> IDLE.
- At most one outstanding read.
- Latency, zero-latency read and no hits: 3 cycles per pixel plus 1. Straight dir: 112*3+1 = 337 cycles from accept to oDone. Diagonal: 225*3+1 = 676.
- iRdValid outside WAIT is ignored.

Optional Feature:
- COLLISION_FULL_SCAN_EN defined:
  - No early termination; the whole footprint is always scanned.
  - Adds output oHitCount[7:0] = number of hit pixels, saturating at 255, held like oHit.
  - oHitX/oHitY still capture the first hit.
- Undefined: early termination at the first hit; no oHitCount port.

Decomposition:
- Shared package car_pkg:
  - direction codes DIR_E..DIR_SE (0..7)
  - footprint width/height constants (14, 8, 15)
  - screen dimensions
  - FSM state enum (IDLE, REQ, WAIT, EVAL, DONE)
  - dims_for_dir function returning W/H
- Sub-module footprint_scanner:
  - loadable col/row counter with W/H inputs
  - advance input
  - last output, asserted when col==W-1 and row==H-1
- The drawer reuses the same dimensions.

Test Plan:
- Clear screen (all 9'h1FF), iX=10, iY=10, iDir=0, read latency 1 -> 112 requests in raster order, first (10,10), last (23,17); oDone with oHit=0.
- WALL_COLOUR at (12,11), iDir=2 at (10,10) -> oHit=1, oHitX=12, oHitY=11, oDone; no request issued after the one for (12,11).
- iX=150, iY=50, iDir=1 -> first 10 pixels are on-screen reads; x=160 is off-screen, so oHit=1, oHitX=160, oHitY=50, and no request is issued with oRdX >= 160.
- Random read latency 1..5 plus spurious iRdValid in IDLE, and iStart pulsed while busy -> request count is exactly 225 (diagonal, clear), the second start is ignored, and results match the first scan.
- iReset asserted in WAIT, then iRdValid arrives -> all outputs 0, oBusy=0, no oDone. A fresh scan then completes normally.
- With COLLISION_FULL_SCAN_EN, two wall pixels at (10,10) and (11,10), iDir=0 -> 112 requests, oHitCount=2, oHitX=10, oHitY=10.
